// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encodings, opcodes, datapath select codes and per-state strobe decode
package ctrl_pkg;
   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADDR = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC_R  = 4'd7,
      S_RWB     = 4'd8,
      S_EXEC_I  = 4'd9,
      S_IWB     = 4'd10,
      S_BRANCH  = 4'd11,
      S_JUMP    = 4'd12,
      S_TRAP    = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OR    = 2'b11;

   localparam logic [1:0] SRCB_RT  = 2'b00;
   localparam logic [1:0] SRCB_4   = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;
   localparam logic [1:0] SRCB_SH  = 2'b11;

   localparam logic [1:0] PC_ALU = 2'b00;
   localparam logic [1:0] PC_OUT = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       src_a;
      logic [1:0] src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       trap;
   } ctrl_t;

   function automatic state_t decode_next(logic [5:0] op);
      case (op)
         OP_RTYPE:     return S_EXEC_R;
         OP_LW, OP_SW: return S_MEMADDR;
         OP_ADDI, OP_ORI: return S_EXEC_I;
         OP_BEQ:       return S_BRANCH;
         OP_J:         return S_JUMP;
         default:      return S_TRAP;
      endcase
   endfunction

   // FETCH's PC/IR load is qualified by ready outside this table
   function automatic ctrl_t decode_state(state_t s, logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:   begin c.mem_read = 1'b1; c.src_b = SRCB_4; c.alu_op = ALU_ADD; c.pc_src = PC_ALU; end
         S_DECODE:  c.src_b = SRCB_SH;
         S_MEMADDR: begin c.src_a = 1'b1; c.src_b = SRCB_IMM; end
         S_MEMRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
         S_MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
         S_MEMWR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
         S_EXEC_R:  begin c.src_a = 1'b1; c.src_b = SRCB_RT; c.alu_op = ALU_FUNCT; end
         S_RWB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
         S_EXEC_I:  begin c.src_a = 1'b1; c.src_b = SRCB_IMM; c.alu_op = (op == OP_ORI) ? ALU_OR : ALU_ADD; end
         S_IWB:     c.reg_write = 1'b1;
         S_BRANCH:  begin c.src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_write_cond = 1'b1; c.pc_src = PC_OUT; end
         S_JUMP:    begin c.pc_write = 1'b1; c.pc_src = PC_JMP; end
         S_TRAP:    c.trap = 1'b1;
         default:   ;
      endcase
      return c;
   endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles and flags when the wait limit is reached
module mem_wait_timer #(
   parameter int unsigned MEM_WAIT_MAX = 15,
   parameter int unsigned CNT_W = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr,
   input  logic en,
   output logic timeout
);
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;

   assign timeout = (cnt == CNT_W'(MEM_WAIT_MAX));
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing MIPS instructions through the shared multi-cycle datapath
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int unsigned ALUOP_W = 2,
   parameter int unsigned MEM_WAIT_MAX = 15,
   parameter int unsigned CNT_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [5:0]         Op_i,
   input  logic               Mem_ready_i,
   output logic               PCWrite_o,
   output logic               PCWriteCond_o,
   output logic               IorD_o,
   output logic               MemRead_o,
   output logic               MemWrite_o,
   output logic               IRWrite_o,
   output logic               MemtoReg_o,
   output logic               RegDst_o,
   output logic               RegWrite_o,
   output logic               ALUSrcA_o,
   output logic [1:0]         ALUSrcB_o,
   output logic [ALUOP_W-1:0] ALUOp_o,
   output logic [1:0]         PCSource_o,
   output logic [3:0]         State_o,
   output logic               Trap_o
);
   state_t     state, nxt;
   logic [5:0] op_q, op_nxt;
   ctrl_t      ctl;
   logic       timeout, waiting, fetch_done;

   assign waiting    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
   assign op_nxt     = (state == S_DECODE) ? Op_i : op_q;
   assign fetch_done = (state == S_FETCH) && Mem_ready_i;

   // ready in the limit cycle still completes the access
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:    nxt = S_FETCH;
         S_FETCH:   nxt = Mem_ready_i ? S_DECODE : timeout ? S_TRAP : S_FETCH;
         S_DECODE:  nxt = decode_next(Op_i);
         S_MEMADDR: nxt = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   nxt = Mem_ready_i ? S_MEMWB : timeout ? S_TRAP : S_MEMRD;
         S_MEMWR:   nxt = Mem_ready_i ? S_FETCH : timeout ? S_TRAP : S_MEMWR;
         S_EXEC_R:  nxt = S_RWB;
         S_EXEC_I:  nxt = S_IWB;
         S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: nxt = S_FETCH;
         default:   nxt = S_TRAP;
      endcase
   end

   mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .CNT_W(CNT_W)) u_timer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr     (nxt != state),
      .en      (waiting && !Mem_ready_i),
      .timeout (timeout)
   );

   // strobes are registered from the state being entered so they line up with State_o
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         state <= S_IDLE;
         op_q  <= '0;
         ctl   <= '0;
      end else begin
         state <= nxt;
         op_q  <= op_nxt;
         ctl   <= decode_state(nxt, op_nxt);
      end

   assign PCWrite_o     = ctl.pc_write || fetch_done;
   assign IRWrite_o     = fetch_done;
   assign PCWriteCond_o = ctl.pc_write_cond;
   assign IorD_o        = ctl.iord;
   assign MemRead_o     = ctl.mem_read;
   assign MemWrite_o    = ctl.mem_write;
   assign MemtoReg_o    = ctl.mem_to_reg;
   assign RegDst_o      = ctl.reg_dst;
   assign RegWrite_o    = ctl.reg_write;
   assign ALUSrcA_o     = ctl.src_a;
   assign ALUSrcB_o     = ctl.src_b;
   assign ALUOp_o       = ALUOP_W'(ctl.alu_op);
   assign PCSource_o    = ctl.pc_src;
   assign State_o       = state;
   assign Trap_o        = ctl.trap;
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main decoder.
- A Moore FSM sequences each MIPS instruction through fetch, decode, execute, memory and writeback, driving datapath strobes per cycle.
- Memory accesses use a ready handshake with a bounded wait. Illegal opcodes and memory timeouts trap to a sticky error state.
- Sits between the instruction register opcode field and the shared multi-cycle datapath (PC, IR, MDR, ALU, register file).

Parameters:
- ALUOP_W, 2, width of ALUOp_o. Encoding occupies bits [1:0]; upper bits are driven 0.
- MEM_WAIT_MAX, 15, maximum cycles a memory state waits for Mem_ready_i before trapping (legal range 1..255).
- CNT_W, 8, wait-counter width; must satisfy 2^CNT_W > MEM_WAIT_MAX.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- Op_i  in  6  opcode field of the instruction register; sampled in DECODE only.
- Mem_ready_i  in  1  memory completion handshake.
- PCWrite_o  out  1  unconditional PC load.
- PCWriteCond_o  out  1  PC load if ALU zero (beq).
- IorD_o  out  1  memory address source: 0 PC, 1 ALUOut.
- MemRead_o  out  1  memory read request.
- MemWrite_o  out  1  memory write request.
- IRWrite_o  out  1  instruction register load.
- MemtoReg_o  out  1  register write data: 0 ALUOut, 1 MDR.
- RegDst_o  out  1  destination: 0 rt, 1 rd.
- RegWrite_o  out  1  register file write.
- ALUSrcA_o  out  1  ALU A operand: 0 PC, 1 rs.
- ALUSrcB_o  out  2  ALU B operand: 00 rt, 01 const 4, 10 sign-extended immediate, 11 immediate<<2.
- ALUOp_o  out  ALUOP_W  ALU operation: 00 add, 01 sub, 10 funct-decoded, 11 or.
- PCSource_o  out  2  next PC: 00 ALU result, 01 ALUOut, 10 jump target.
- State_o  out  4  current state encoding, for debug.
- Trap_o  out  1  sticky error flag.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADDR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC_R=7, RWB=8, EXEC_I=9, IWB=10, BRANCH=11, JUMP=12, TRAP=15.
- Reset (rst_i low, asynchronous): state IDLE, wait counter 0, all outputs 0, ALUOp_o 0, State_o 0. Reset asserted mid-instruction aborts it immediately; no write strobe may stay asserted.
- IDLE: all outputs 0. Always moves to FETCH on the next clock.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite = Mem_ready_i (Mealy qualification, FETCH only).
  - Mem_ready_i=1 -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op_i:
  - 000000 -> EXEC_R
  - 100011 (lw) or 101011 (sw) -> MEMADDR
  - 001000 (addi) or 001101 (ori) -> EXEC_I
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other opcode -> TRAP
- Op_i is latched in DECODE into an internal register. EXEC_I, IWB and MEMADDR use the latched value, not live Op_i.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Latched lw -> MEMRD; latched sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Mem_ready_i -> MEMWB.
- MEMWR: MemWrite=1, IorD=1. Mem_ready_i -> FETCH.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00 for addi, 11 for ori -> IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- Wait counter (FETCH, MEMRD, MEMWR only):
  - Cleared on entry to each of these states.
  - Increments each cycle Mem_ready_i=0.
  - Counter == MEM_WAIT_MAX with Mem_ready_i still 0 -> TRAP.
  - Mem_ready_i=1 in the same cycle as the limit wins: normal transition, no trap.
- TRAP: all strobes 0, Trap_o=1. Stays in TRAP until reset.
- Unlisted output values in any state are 0.
- Latencies: R/addi/ori 4 cycles; beq 3; j 3; sw 4; lw 5. Each assumes Mem_ready_i=1 on the first cycle of every memory state.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ORI, OP_BEQ, OP_J)
  - ALUOp constants
  - ALUSrcB and PCSource constants
- One sub-module, mem_wait_timer: the counter, clear/enable inputs and a timeout output, parametrised by MEM_WAIT_MAX and CNT_W.
- The FSM and output decode live in multicycle_control.

Test Plan:
- Reset release, Mem_ready_i=1, Op_i=000000 -> State_o sequence 0,1,2,7,8,1. RegWrite_o=1 and RegDst_o=1 only in state 8.
- lw (100011) with Mem_ready_i low for 3 cycles in MEMRD -> MemRead_o=1 and IorD_o=1 held 4 cycles, then MEMWB with MemtoReg_o=1, no trap.
- Op_i=111111 in DECODE -> State_o=15, Trap_o=1 persists 20 cycles; rst_i low pulse -> State_o=0 and Trap_o=0 immediately, without waiting for a clock edge.
- Mem_ready_i held 0 in FETCH with MEM_WAIT_MAX=15 -> trap after exactly 16 FETCH cycles. Ready arriving on cycle 16 -> DECODE, no trap.
- ori (001101) -> EXEC_I with ALUOp_o=11, ALUSrcB_o=10. Op_i changed to 000100 during EXEC_I -> still IWB with RegDst_o=0.
- rst_i asserted during MEMWR with MemWrite_o=1 -> MemWrite_o=0 asynchronously. After release, IDLE then FETCH.
